cv32e40s_mpu_arbiter: RTL

- Shares one data-side MPU instance between two requesters: port 0 is the core LSU and port 1 is the XIF memory interface.
- Arbitrates requests, holds each grant until the MPU accepts it, and tracks outstanding transactions in an ID FIFO so that responses return to the correct requester.
- Generates the MPU sequencing inputs: the one-pending indication and the error-wait mode select.
- Sits between the LSU/XIF request muxing and the MPU; it is combinational pass-through except for the grant lock, the FIFO and the pointer.

---
 rtl/cv32e40s_pkg.sv | 37 +++
 rtl/cv32e40s_mpu_arb_id_fifo.sv | 61 ++++++
 rtl/cv32e40s_mpu_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/cv32e40s_pkg.sv
// Shared types for the data-side MPU arbiter slice: OBI request/response
// structs, MPU status and the 1-bit arbiter port ID.
package cv32e40s_pkg;

  typedef enum logic [1:0] {
    MPU_OK       = 2'h0,
    MPU_RE_FAULT = 2'h1,
    MPU_WR_FAULT = 2'h2
  } mpu_status_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [5:0]  atop;
    logic [1:0]  memtype;
    logic [2:0]  prot;
    logic        dbg;
  } obi_data_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_data_resp_t;

  typedef struct packed {
    obi_data_resp_t bus_resp;
    mpu_status_e    mpu_status;
  } data_resp_t;

  // Port 0 is the LSU, port 1 the XIF memory interface
  typedef logic arb_id_t;
  localparam arb_id_t ARB_ID_LSU = 1'b0;
  localparam arb_id_t ARB_ID_XIF = 1'b1;

endpackage

// File: rtl/cv32e40s_mpu_arb_id_fifo.sv
// In-order FIFO of 1-bit requester IDs for outstanding MPU transactions.
// Entry 0 is always the head; a pop shifts the array down by one.
module cv32e40s_mpu_arb_id_fifo
  import cv32e40s_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  arb_id_t    push_id,
  output arb_id_t    head,
  output logic [2:0] cnt,
  output logic [2:0] cnt_n,
  output logic       full,
  output logic       empty
);

  logic [2:0] cnt_q;
  logic [2:0] wr_idx;
  arb_id_t    mem_q [DEPTH];
  arb_id_t    mem_n [DEPTH];

  assign cnt_n  = cnt_q + {2'b00, push} - {2'b00, pop};
  assign cnt    = cnt_q;
  assign full   = (cnt_q == 3'(DEPTH));
  assign empty  = (cnt_q == 3'd0);
  assign head   = mem_q[0];
  // On a simultaneous pop the tail slot has already moved down one place
  assign wr_idx = cnt_q - {2'b00, pop};

  always_comb begin
    mem_n = mem_q;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem_n[i] = mem_q[i+1];
      end
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_idx == 3'(i)) begin
          mem_n[i] = push_id;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_n;
  end

endmodule

// File: rtl/cv32e40s_mpu_arbiter.sv
// Shares one data-side MPU between the LSU (port 0) and XIF (port 1), holding
// each grant until accepted and routing in-order responses back by ID.
module cv32e40s_mpu_arbiter
  import cv32e40s_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter bit RR_ENABLE       = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          p0_trans_valid_i,
  output logic          p0_trans_ready_o,
  input  obi_data_req_t p0_trans_i,
  output logic          p0_resp_valid_o,
  output data_resp_t    p0_resp_o,

  input  logic          p1_trans_valid_i,
  output logic          p1_trans_ready_o,
  input  obi_data_req_t p1_trans_i,
  output logic          p1_resp_valid_o,
  output data_resp_t    p1_resp_o,
  output logic          p1_mpu_err_o,

  output logic          mpu_trans_valid_o,
  input  logic          mpu_trans_ready_i,
  output obi_data_req_t mpu_trans_o,
  input  logic          mpu_resp_valid_i,
  input  data_resp_t    mpu_resp_i,
  input  logic          mpu_err_i,
  output logic          mpu_err_wait_o,
  output logic          one_txn_pend_n_o
);

  logic       lock_q;
  arb_id_t    lock_id_q;
  arb_id_t    rr_q;
  arb_id_t    grant;
  logic       gnt_valid;
  logic       both_valid;
  logic       accept;
  logic       push;
  logic       pop;
  arb_id_t    fifo_head;
  logic [2:0] fifo_cnt;
  logic [2:0] fifo_cnt_n;
  logic       fifo_full;
  logic       fifo_empty;

  assign both_valid = p0_trans_valid_i && p1_trans_valid_i;

  always_comb begin
    grant = ARB_ID_LSU;
    if (lock_q) begin
      grant = lock_id_q;
    end else if (both_valid) begin
      grant = RR_ENABLE ? rr_q : ARB_ID_LSU;
    end else if (p1_trans_valid_i) begin
      grant = ARB_ID_XIF;
    end
  end

  assign gnt_valid         = (grant == ARB_ID_XIF) ? p1_trans_valid_i : p0_trans_valid_i;
  assign mpu_trans_valid_o = gnt_valid && !fifo_full;
  assign mpu_trans_o       = (grant == ARB_ID_XIF) ? p1_trans_i : p0_trans_i;
  assign p0_trans_ready_o  = mpu_trans_ready_i && !fifo_full && (grant == ARB_ID_LSU);
  assign p1_trans_ready_o  = mpu_trans_ready_i && !fifo_full && (grant == ARB_ID_XIF);
  assign accept            = mpu_trans_valid_o && mpu_trans_ready_i;

  // XIF faults are reported immediately, LSU faults come back as a response
  assign mpu_err_wait_o = (grant == ARB_ID_LSU);
  assign p1_mpu_err_o   = mpu_err_i && (grant == ARB_ID_XIF) && mpu_trans_valid_o;

  // An XIF request that faults immediately never gets an MPU response
  assign push = accept && !(mpu_err_i && (grant == ARB_ID_XIF));
  assign pop  = mpu_resp_valid_i && !fifo_empty;

  assign p0_resp_valid_o  = pop && (fifo_head == ARB_ID_LSU);
  assign p1_resp_valid_o  = pop && (fifo_head == ARB_ID_XIF);
  assign p0_resp_o        = mpu_resp_i;
  assign p1_resp_o        = mpu_resp_i;
  assign one_txn_pend_n_o = (fifo_cnt_n == 3'd1);

  cv32e40s_mpu_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .push_id (grant),
    .head    (fifo_head),
    .cnt     (fifo_cnt),
    .cnt_n   (fifo_cnt_n),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Grant is frozen from the first unaccepted cycle until the MPU takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_id_q <= ARB_ID_LSU;
      rr_q      <= ARB_ID_LSU;
    end else begin
      if (mpu_trans_valid_o && !mpu_trans_ready_i) begin
        lock_q    <= 1'b1;
        lock_id_q <= grant;
      end else if (accept) begin
        lock_q    <= 1'b0;
      end
      if (accept && both_valid) begin
        rr_q <= ~rr_q;
      end
    end
  end

  a_resp_without_txn : assert property (@(posedge clk) disable iff (!rst_n)
    !(mpu_resp_valid_i && fifo_empty));

endmodule
